// File: rtl/flag_update_unit.sv
// Flag-commit stage: evaluates an instruction's condition against the C/Z flags, then
// either commits new flags and grants writeback or retires the op as skipped.
module flag_update_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_class_i,
  input  logic [1:0]       cond_i,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_carry_i,
  output logic             c_flag_o,
  output logic             z_flag_o,
  output logic             wr_en_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             skipped_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StEval   = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;
  localparam logic [1:0] StSkip   = 2'd3;

  localparam logic [1:0] OpAdd  = 2'b00;
  localparam logic [1:0] OpNone = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       cond_q, cond_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             wr_en_q, wr_en_d;
  logic             done_q, done_d;
  logic             skipped_q, skipped_d;
  logic             pass;

  // Reserved cond 2'b11 matches no term, so it never passes.
  assign pass = (cond_q == 2'b00) | ((cond_q == 2'b10) & c_q) | ((cond_q == 2'b01) & z_q);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cond_d    = cond_q;
    res_d     = res_q;
    carry_d   = carry_q;
    c_d       = c_q;
    z_d       = z_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    skipped_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The retire cycle shows state IDLE but must still reject a new start.
        if (start_i && !done_q) begin
          op_d    = op_class_i;
          cond_d  = cond_i;
          res_d   = alu_result_i;
          carry_d = alu_carry_i;
          state_d = StEval;
        end
      end
      StEval: begin
        state_d = pass ? StCommit : StSkip;
      end
      StCommit: begin
        if (op_q == OpAdd) c_d = carry_q;
        if (op_q != OpNone) z_d = (res_q == '0);
        wr_en_d = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StSkip: begin
        done_d    = 1'b1;
        skipped_d = 1'b1;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      op_q      <= '0;
      cond_q    <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      skipped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cond_q    <= cond_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      c_q       <= c_d;
      z_q       <= z_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      skipped_q <= skipped_d;
    end
  end

  assign c_flag_o  = c_q;
  assign z_flag_o  = z_q;
  assign wr_en_o   = wr_en_q;
  assign done_o    = done_q;
  assign skipped_o = skipped_q;
  assign busy_o    = (state_q != StIdle);

endmodule
